// File: rtl/exercicio3_pkg.sv
// Shared definitions for the exercicio3 sum-of-products block:
// sweep FSM states, sweep length and the reference truth table.
package exercicio3_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

   // Number of input combinations enumerated by the sweep
   localparam int SWEEP_LEN = 16;

   // Last index visited by the sweep
   localparam logic [3:0] LAST_INDEX = 4'(SWEEP_LEN - 1);

   // Truth table of f = a | b | (~c & d), bit i for {a,b,c,d} = i
   localparam logic [15:0] EXPECTED_TT = 16'hFFF2;

   // Number of ones in EXPECTED_TT
   localparam int EXPECTED_MINTERMS = 13;

endpackage : exercicio3_pkg

// File: rtl/exercicio3_fn.sv
// Combinational core of the block: f = a | b | (~c & d).
// Instantiated once for the port path and once for the sweep path.
module exercicio3_fn (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic y
);

   // Pure sum of products, no state
   assign y = a | b | (~c & d);

endmodule : exercicio3_fn

// File: rtl/exercicio3_sop.sv
// Top of the exercicio3 block. Provides three views of the same
// function: a zero-latency combinational output, a registered output
// qualified by in_valid, and a self-test sweep that enumerates all 16
// input combinations and records the truth table and its minterm count.
module exercicio3_sop
   import exercicio3_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        in_valid,
   output logic        f,
   output logic        f_q,
   output logic        f_valid,
   input  logic        sweep_start,
   output logic        sweep_busy,
   output logic        sweep_done,
   output logic [15:0] truth_table,
   output logic [4:0]  minterm_count
);

   sweep_state_t state_reg;
   sweep_state_t state_next;

   logic [3:0]  index_reg;
   logic        sweep_f;

   // Port path: evaluates the function on the live operands
   exercicio3_fn u_fn_port (
      .a (a),
      .b (b),
      .c (c),
      .d (d),
      .y (f)
   );

   // Sweep path: evaluates the function on the internal index, a = MSB
   exercicio3_fn u_fn_sweep (
      .a (index_reg[3]),
      .b (index_reg[2]),
      .c (index_reg[1]),
      .d (index_reg[0]),
      .y (sweep_f)
   );

   // Registered path: capture f when the operands are qualified
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q     <= 1'b0;
         f_valid <= 1'b0;
      end else begin
         f_valid <= in_valid;
         if (in_valid) begin
            f_q <= f;
         end
      end
   end

   // Sweep FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Sweep FSM next state: start is only honoured from IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (sweep_start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (index_reg == LAST_INDEX) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sweep FSM outputs: Moore decode of the current state
   always_comb begin
      sweep_busy = 1'b0;
      sweep_done = 1'b0;
      case (state_reg)
         RUN:     sweep_busy = 1'b1;
         DONE:    sweep_done = 1'b1;
         default: begin
            sweep_busy = 1'b0;
            sweep_done = 1'b0;
         end
      endcase
   end

   // Sweep datapath: clear results on start, fill one table bit per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_reg     <= 4'd0;
         truth_table   <= 16'h0000;
         minterm_count <= 5'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (sweep_start) begin
                  index_reg     <= 4'd0;
                  truth_table   <= 16'h0000;
                  minterm_count <= 5'd0;
               end
            end
            RUN: begin
               truth_table[index_reg] <= sweep_f;
               minterm_count          <= minterm_count + {4'd0, sweep_f};
               if (index_reg != LAST_INDEX) begin
                  index_reg <= index_reg + 4'd1;
               end
            end
            default: begin
               // DONE: results hold until the next start
            end
         endcase
      end
   end

endmodule : exercicio3_sop

// File: tb/tb_exercicio3_sop.sv
// Self-checking bench for exercicio3_sop: a behavioural model tracks the
// expected outputs every cycle, directed scenarios pin specific values.
module tb_exercicio3_sop;
   import exercicio3_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic        in_valid = 1'b0;
   logic        sweep_start = 1'b0;
   logic        f, f_q, f_valid, sweep_busy, sweep_done;
   logic [15:0] truth_table;
   logic [4:0]  minterm_count;

   int checks = 0;
   int errors = 0;

   exercicio3_sop dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .a             (a),
      .b             (b),
      .c             (c),
      .d             (d),
      .in_valid      (in_valid),
      .f             (f),
      .f_q           (f_q),
      .f_valid       (f_valid),
      .sweep_start   (sweep_start),
      .sweep_busy    (sweep_busy),
      .sweep_done    (sweep_done),
      .truth_table   (truth_table),
      .minterm_count (minterm_count)
   );

   always #5 clk = ~clk;

   function automatic logic fref(input logic [3:0] v);
      return v[3] || v[2] || (!v[1] && v[0]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] ref_tt;
   logic        m_fq = 1'b0;
   logic        m_fv = 1'b0;
   logic        m_running = 1'b0;
   logic        m_done = 1'b0;
   int          m_k = 0;   // table entries filled since the last start

   initial begin
      ref_tt = '0;
      for (int i = 0; i < 16; i++) ref_tt[i] = fref(4'(i));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_fq <= 1'b0; m_fv <= 1'b0;
         m_running <= 1'b0; m_done <= 1'b0; m_k <= 0;
      end else begin
         m_fv <= in_valid;
         if (in_valid) m_fq <= fref({a, b, c, d});
         if (m_done) m_done <= 1'b0;
         else if (m_running) begin
            m_k <= m_k + 1;
            if (m_k + 1 == SWEEP_LEN) begin
               m_running <= 1'b0;
               m_done <= 1'b1;
            end
         end else if (sweep_start) begin
            m_running <= 1'b1;
            m_k <= 0;
         end
      end
   end

   function automatic logic [15:0] exp_tt(input int k);
      logic [31:0] mask;
      mask = (k >= 16) ? 32'hFFFF : ((32'd1 << k) - 32'd1);
      return ref_tt & mask[15:0];
   endfunction

   // Compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      logic [15:0] t;
      t = exp_tt(m_k);
      chk("f", 32'(f), 32'(fref({a, b, c, d})));
      chk("f_q", 32'(f_q), 32'(m_fq));
      chk("f_valid", 32'(f_valid), 32'(m_fv));
      chk("sweep_busy", 32'(sweep_busy), 32'(m_running));
      chk("sweep_done", 32'(sweep_done), 32'(m_done));
      chk("truth_table", 32'(truth_table), 32'(t));
      chk("minterm_count", 32'(minterm_count), 32'($countones(t)));
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_f_q"}, 32'(f_q), 0);
      chk({tag, "_f_valid"}, 32'(f_valid), 0);
      chk({tag, "_busy"}, 32'(sweep_busy), 0);
      chk({tag, "_done"}, 32'(sweep_done), 0);
      chk({tag, "_tt"}, 32'(truth_table), 0);
      chk({tag, "_cnt"}, 32'(minterm_count), 0);
   endtask

   // Runs one sweep; optionally re-pulses start mid-run and toggles a..d
   task automatic run_sweep(input bit repulse, input bit toggle,
                            output int lat, output int busy_n, output int done_n);
      lat = -1; busy_n = 0; done_n = 0;
      sweep_start = 1'b1;
      tick;
      sweep_start = 1'b0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         if (sweep_busy) busy_n++;
         if (sweep_done) begin
            done_n++;
            lat = i;
         end
         sweep_start = (repulse && (i == 5 || i == 12)) ? 1'b1 : 1'b0;
         if (toggle) begin
            {a, b, c, d} = 4'($urandom_range(0, 15));
            in_valid = 1'($urandom_range(0, 1));
         end
         tick;
      end
      sweep_start = 1'b0;
      chk("sweep_timeout", 32'(lat < 0), 0);
      chk("done_single", 32'(sweep_done), 0);
   endtask

   initial begin
      int lat0, lat1, bn, dn;

      // Pin the model against hand-derived constants
      #1;
      chk("model_tt_pin", 32'(ref_tt), 32'h0000_FFF2);
      chk("model_tt_pkg", 32'(ref_tt), 32'(EXPECTED_TT));
      chk("model_cnt_pin", $countones(ref_tt), 13);

      // Reset
      #1 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      tick; tick;
      rst_n = 1'b1;
      tick;

      // Exhaustive combinational check, 10 time units per value
      for (int i = 0; i < 16; i++) begin
         {a, b, c, d} = 4'(i);
         #5;
         chk($sformatf("comb_%0d", i), 32'(f), (i == 0 || i == 2 || i == 3) ? 0 : 1);
         $display("comb abcd=%b f=%b", 4'(i), f);
         #5;
      end
      tick;

      // Registered path
      {a, b, c, d} = 4'b0011; in_valid = 1'b1;
      tick;
      chk("reg1_f_q", 32'(f_q), 0);
      chk("reg1_f_valid", 32'(f_valid), 1);
      {a, b, c, d} = 4'b0001;
      tick;
      chk("reg2_f_q", 32'(f_q), 1);
      chk("reg2_f_valid", 32'(f_valid), 1);
      in_valid = 1'b0; {a, b, c, d} = 4'b0010;
      tick;
      chk("reg3_f_q", 32'(f_q), 1);
      chk("reg3_f_valid", 32'(f_valid), 0);
      $display("registered path f_q=%b f_valid=%b", f_q, f_valid);

      // Plain sweep
      run_sweep(1'b0, 1'b0, lat0, bn, dn);
      chk("sweep_busy_cycles", bn, 16);
      chk("sweep_done_pulses", dn, 1);
      chk("sweep_latency", lat0, 17);
      chk("sweep_tt", 32'(truth_table), 32'h0000_FFF2);
      chk("sweep_cnt", 32'(minterm_count), 13);
      $display("sweep tt=%h cnt=%0d lat=%0d", truth_table, minterm_count, lat0);
      tick; tick;
      chk("sweep_hold_tt", 32'(truth_table), 32'h0000_FFF2);

      // Start re-pulsed during RUN is ignored
      run_sweep(1'b1, 1'b0, lat1, bn, dn);
      chk("repulse_latency", lat1, lat0);
      chk("repulse_busy_cycles", bn, 16);
      chk("repulse_tt", 32'(truth_table), 32'h0000_FFF2);
      $display("repulse sweep tt=%h lat=%0d", truth_table, lat1);
      repeat (3) tick;
      chk("repulse_no_restart", 32'(sweep_busy), 0);

      // Reset at sweep cycle 7
      in_valid = 1'b1; {a, b, c, d} = 4'b1000;
      sweep_start = 1'b1;
      tick;
      sweep_start = 1'b0;
      repeat (7) tick;
      chk("pre_reset_busy", 32'(sweep_busy), 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      $display("mid-sweep reset busy=%b tt=%h", sweep_busy, truth_table);
      in_valid = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      run_sweep(1'b0, 1'b0, lat1, bn, dn);
      chk("post_reset_tt", 32'(truth_table), 32'h0000_FFF2);
      chk("post_reset_cnt", 32'(minterm_count), 13);
      $display("post-reset sweep tt=%h cnt=%0d", truth_table, minterm_count);

      // Random operands during a sweep
      run_sweep(1'b0, 1'b1, lat1, bn, dn);
      chk("toggle_tt", 32'(truth_table), 32'h0000_FFF2);
      chk("toggle_latency", lat1, 17);
      $display("toggled sweep tt=%h", truth_table);

      // Random soak, model checks every cycle
      for (int i = 0; i < 400; i++) begin
         {a, b, c, d} = 4'($urandom_range(0, 15));
         in_valid = 1'($urandom_range(0, 1));
         sweep_start = ($urandom_range(0, 19) == 0);
         tick;
      end
      sweep_start = 1'b0;
      repeat (20) tick;
      $display("random soak complete");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_exercicio3_sop

// File: doc/exercicio3_sop.md
Name: exercicio3_sop

Overview:
- Evaluates the 4-input boolean function f = a | b | (~c & d) on a combinational path, a registered path, and a self-test sweep path.
- The sweep enumerates all 16 input combinations and captures the full truth table plus its minterm count.
- Used as a small logic-cell block and as a self-checking reference for the function.

Parameters:
- none (function and widths are fixed)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a  input  1  operand a
- b  input  1  operand b
- c  input  1  operand c (used inverted)
- d  input  1  operand d
- in_valid  input  1  qualifies a..d for the registered path
- f  output  1  combinational a | b | (~c & d), zero latency
- f_q  output  1  registered f of last qualified inputs
- f_valid  output  1  high one cycle after in_valid
- sweep_start  input  1  pulse, begins truth-table sweep
- sweep_busy  output  1  high while sweep runs
- sweep_done  output  1  one-cycle pulse at sweep end
- truth_table  output  16  bit i = f for {a,b,c,d} = i (a = MSB)
- minterm_count  output  5  number of 1 bits in truth_table

Behaviour:
- Function: f = a OR b OR (NOT c AND d). Pure combinational, no clock or reset dependence. Operands are 1-bit; X/Z are not treated specially.
- Reset (rst_n low, asynchronous, any time): f_q=0, f_valid=0, sweep_busy=0, sweep_done=0, truth_table=16'h0000, minterm_count=0, FSM to IDLE, index=0.
- Registered path: on a rising edge with in_valid=1, f_q <= f(a,b,c,d) and f_valid <= 1. With in_valid=0, f_valid <= 0 and f_q holds. Latency is 1 cycle.
- Sweep FSM states: IDLE, RUN, DONE.
- IDLE: on sweep_start=1, go to RUN, index<=0, truth_table<=0, minterm_count<=0. Otherwise hold the previous results.
- RUN: each cycle evaluates f on the internal 4-bit index {a,b,c,d}=index, sets truth_table[index], and adds the result to minterm_count. After index 15 (16 cycles), go to DONE. Otherwise index increments. sweep_busy=1 in RUN.
- DONE: sweep_done=1 for exactly one cycle, then IDLE. Results hold until the next sweep_start or reset.
- sweep_start while in RUN or DONE is ignored; a sweep is never restarted mid-flight.
- The sweep does not use port inputs a..d. The registered and combinational paths keep operating during a sweep, fully independent.
- Expected sweep result: truth_table=16'hFFF2, minterm_count=13.
- Reset mid-sweep aborts immediately to the reset state; partial results are discarded.
- minterm_count is 5 bits so that 16 is representable; no wrap.

Decomposition:
- Shared package exercicio3_pkg: FSM state enum (IDLE/RUN/DONE), constant SWEEP_LEN=16, constant EXPECTED_TT=16'hFFF2.
- One sub-module exercicio3_fn: the combinational function, 4 inputs to 1 output. It is instantiated twice: once for the port path, once for the sweep index path.

Test Plan:
- Exhaustive combinational check of all 16 {a,b,c,d} values, holding each 10 time units -> f=0 only for 0000, 0010, 0011; f=1 for the other 13. Specifically 0001 -> 1 and 1000 -> 1.
- Registered path: drive a=0,b=0,c=1,d=1 with in_valid=1 for one cycle -> next cycle f_q=0, f_valid=1. Then drive 0,0,0,1 with in_valid=1 -> f_q=1. Then in_valid=0 -> f_valid=0 and f_q holds 1.
- Sweep: pulse sweep_start from IDLE -> sweep_busy high for 16 cycles, then sweep_done pulses once, truth_table=16'hFFF2, minterm_count=13.
- sweep_start re-pulsed during RUN -> ignored; completes at the original time with the same result.
- Assert rst_n low at sweep cycle 7 -> all outputs 0 asynchronously. After release, a new sweep again yields 16'hFFF2.
- Toggle a..d randomly during a sweep -> the sweep result is unaffected (16'hFFF2), and f tracks the port inputs throughout.
